// File: rtl/ctrl_word_pkg.sv
// Shared layout of the 42-bit decode->execute control word.
// The decoder's packing stage and the execute-side unpack register both use it.
package ctrl_word_pkg;

  localparam int CTRL_W = 42;

  localparam int AF_LSB       = 38;
  localparam int I_BIT        = 37;
  localparam int ALU_MUX_BIT  = 36;
  localparam int SHIFT_LSB    = 33;
  localparam int CAD_LSB      = 28;
  localparam int GP_WE_BIT    = 27;
  localparam int GP_MUX_LSB   = 24;
  localparam int BF_LSB       = 20;
  localparam int PC_MUX_LSB   = 18;
  localparam int SPR_MUX_BIT  = 17;
  localparam int MEM_WREN_BIT = 16;
  localparam int MEM_RREN_BIT = 15;
  localparam int RS_LSB       = 10;
  localparam int RT_LSB       = 5;
  localparam int RD_LSB       = 0;

  typedef struct packed {
    logic [3:0] af;
    logic       i;
    logic       alu_mux_sel;
    logic [2:0] shift_type;
    logic [4:0] cad;
    logic       gp_we;
    logic [2:0] gp_mux_sel;
    logic [3:0] bf;
    logic [1:0] pc_mux_select;
    logic       spr_mux_sel;
    logic       mem_wren;
    logic       mem_rren;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } ctrl_word_t;

  function automatic ctrl_word_t unpack(input logic [CTRL_W-1:0] w);
    ctrl_word_t c;
    c.af            = w[AF_LSB +: 4];
    c.i             = w[I_BIT];
    c.alu_mux_sel   = w[ALU_MUX_BIT];
    c.shift_type    = w[SHIFT_LSB +: 3];
    c.cad           = w[CAD_LSB +: 5];
    c.gp_we         = w[GP_WE_BIT];
    c.gp_mux_sel    = w[GP_MUX_LSB +: 3];
    c.bf            = w[BF_LSB +: 4];
    c.pc_mux_select = w[PC_MUX_LSB +: 2];
    c.spr_mux_sel   = w[SPR_MUX_BIT];
    c.mem_wren      = w[MEM_WREN_BIT];
    c.mem_rren      = w[MEM_RREN_BIT];
    c.rs            = w[RS_LSB +: 5];
    c.rt            = w[RT_LSB +: 5];
    c.rd            = w[RD_LSB +: 5];
    return c;
  endfunction

endpackage

// File: rtl/ctrl_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush.
// in_ready depends only on the skid register, so there is no ready path from downstream.
module ctrl_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid, skid_valid;
  logic [W-1:0] main_data, skid_data;
  logic         in_fire, main_free;

  assign in_ready  = !skid_valid;
  assign in_fire   = in_valid && in_ready;
  assign main_free = !main_valid || out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        // in_ready is low while skid holds a word, so this only clears skid
        skid_valid <= in_fire;
        if (in_fire) skid_data <= in_data;
      end else begin
        main_valid <= in_fire;
        if (in_fire) main_data <= in_data;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/ctrl_word_unpack_reg.sv
// Decode->execute boundary register: skid-buffered control word, unpacked into
// fields with side-effecting fields gated by out_valid, plus a saturating stall counter.
module ctrl_word_unpack_reg #(
  parameter int CTRL_W      = 42,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_packed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             af,
  output logic                   i,
  output logic                   alu_mux_sel,
  output logic [2:0]             shift_type,
  output logic [4:0]             cad,
  output logic                   gp_we,
  output logic [2:0]             gp_mux_sel,
  output logic [3:0]             bf,
  output logic [1:0]             pc_mux_select,
  output logic                   spr_mux_sel,
  output logic                   mem_wren,
  output logic                   mem_rren,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  import ctrl_word_pkg::*;

  logic [CTRL_W-1:0] head;
  ctrl_word_t        w;

  ctrl_skid_buf #(.W(CTRL_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_packed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign w = unpack(head);

  assign af          = w.af;
  assign i           = w.i;
  assign alu_mux_sel = w.alu_mux_sel;
  assign shift_type  = w.shift_type;
  assign cad         = w.cad;
  assign gp_mux_sel  = w.gp_mux_sel;
  assign bf          = w.bf;
  assign spr_mux_sel = w.spr_mux_sel;
  assign rs          = w.rs;
  assign rt          = w.rt;
  assign rd          = w.rd;

  // Bubbles must never write registers/memory or redirect the PC.
  assign gp_we         = w.gp_we    && out_valid;
  assign mem_wren      = w.mem_wren && out_valid;
  assign mem_rren      = w.mem_rren && out_valid;
  assign pc_mux_select = out_valid ? w.pc_mux_select : 2'b00;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != {STALL_CNT_W{1'b1}})
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
  end

endmodule

// File: tb/tb_ctrl_word_unpack_reg.sv
// Directed bench for ctrl_word_unpack_reg: expected words queued at acceptance,
// a negedge monitor pops and compares on every output beat.
module tb_ctrl_word_unpack_reg;
  import ctrl_word_pkg::*;

  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [41:0]   in_packed = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    af;
  logic          i;
  logic          alu_mux_sel;
  logic [2:0]    shift_type;
  logic [4:0]    cad;
  logic          gp_we;
  logic [2:0]    gp_mux_sel;
  logic [3:0]    bf;
  logic [1:0]    pc_mux_select;
  logic          spr_mux_sel;
  logic          mem_wren;
  logic          mem_rren;
  logic [4:0]    rs, rt, rd;
  logic [SW-1:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [41:0] sb_q[$];

  ctrl_word_unpack_reg #(.CTRL_W(42), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_packed(in_packed),
    .out_valid(out_valid), .out_ready(out_ready),
    .af(af), .i(i), .alu_mux_sel(alu_mux_sel), .shift_type(shift_type), .cad(cad),
    .gp_we(gp_we), .gp_mux_sel(gp_mux_sel), .bf(bf), .pc_mux_select(pc_mux_select),
    .spr_mux_sel(spr_mux_sel), .mem_wren(mem_wren), .mem_rren(mem_rren),
    .rs(rs), .rt(rt), .rd(rd), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] got_word();
    return {af, i, alu_mux_sel, shift_type, cad, gp_we, gp_mux_sel, bf,
            pc_mux_select, spr_mux_sel, mem_wren, mem_rren, rs, rt, rd};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive after the edge, then at negedge check in_ready and record the acceptance.
  task automatic cyc(input logic v, input logic [41:0] word, input logic ordy,
                     input logic fl, input logic exp_rdy);
    @(posedge clk); #1;
    in_valid = v; in_packed = word; out_ready = ordy; flush = fl;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (fl) sb_q.delete();
    else if (v && exp_rdy) sb_q.push_back(word);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_unexpected: got %0h expected none", got_word());
      end else begin
        logic [41:0] e;
        e = sb_q.pop_front();
        if (got_word() !== e) begin
          miscompares++;
          $display("FAIL scoreboard_word: got %0h expected %0h", got_word(), e);
        end
      end
    end
  end

  localparam logic [41:0] W1 = 42'h2A_5555_5555;
  localparam logic [41:0] W2 = 42'h15_AAAA_AAAA;
  localparam logic [41:0] W3 = 42'h3FF_0000_0001;
  localparam logic [41:0] W4 = 42'h123_4567_89AB;
  localparam logic [41:0] W5 = 42'h0F0_F0F0_F0F0;
  localparam logic [41:0] W6 = 42'h111_1111_1111;
  localparam logic [41:0] W7 = 42'h222_2222_2222;
  localparam logic [41:0] W8 = 42'h333_3333_3333;
  localparam logic [41:0] W9 = 42'h044_4444_4444;
  localparam logic [41:0] W10 = 42'h1A5_5A5A_0F0F;

  initial begin
    ctrl_word_t g;
    g = '0;
    g.af = 4'h6; g.gp_we = 1'b1; g.mem_wren = 1'b1; g.mem_rren = 1'b1;
    g.pc_mux_select = 2'b11; g.rd = 5'h13; g.rs = 5'h07;

    // Reset held 3 cycles with a live input.
    in_valid = 1'b1; in_packed = W1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_fields", 64'(got_word()), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Streaming, one-cycle latency.
    cyc(1, W1, 1, 0, 1); chk("s_ov0", 64'(out_valid), 64'd0);
    cyc(1, W2, 1, 0, 1); chk("s_ov1", 64'(out_valid), 64'd1); chk("s_rd1", 64'(rd), 64'h15);
    cyc(0, '0, 1, 0, 1); chk("s_ov2", 64'(out_valid), 64'd1); chk("s_rd2", 64'(rd), 64'h0A);
    cyc(0, '0, 1, 0, 1); chk("s_ov3", 64'(out_valid), 64'd0); chk("s_stall", 64'(stall_cnt), 64'd0);

    // Backpressure: two accepted, third waits, stall counts.
    cyc(1, W3, 0, 0, 1); chk("bp_stall0", 64'(stall_cnt), 64'd0);
    cyc(1, W4, 0, 0, 1); chk("bp_stall0b", 64'(stall_cnt), 64'd0);
    cyc(1, W5, 0, 0, 0); chk("bp_stall1", 64'(stall_cnt), 64'd1);
    cyc(1, W5, 0, 0, 0); chk("bp_stall2", 64'(stall_cnt), 64'd2);
    cyc(1, W5, 1, 0, 0); chk("bp_stall3", 64'(stall_cnt), 64'd3);
    cyc(1, W5, 1, 0, 1); chk("bp_hold3", 64'(stall_cnt), 64'd3);
    cyc(0, '0, 1, 0, 1); chk("bp_ov", 64'(out_valid), 64'd1);
    cyc(0, '0, 1, 0, 1); chk("bp_drained", 64'(out_valid), 64'd0);
    chk("bp_q_empty", 64'(sb_q.size()), 64'd0);

    // Flush with skid full, then flush while in_ready=1; neither word may appear.
    cyc(1, W6, 0, 0, 1);
    cyc(1, W7, 0, 0, 1); chk("fl_stall3", 64'(stall_cnt), 64'd3);
    cyc(1, W8, 0, 1, 0); chk("fl_ov_same", 64'(out_valid), 64'd1); chk("fl_stall4", 64'(stall_cnt), 64'd4);
    cyc(1, W9, 0, 1, 1); chk("fl_ov0", 64'(out_valid), 64'd0); chk("fl_stall5", 64'(stall_cnt), 64'd5);
    cyc(0, '0, 1, 0, 1); chk("fl_ov_after", 64'(out_valid), 64'd0); chk("fl_stall_kept", 64'(stall_cnt), 64'd5);

    // Bubble gating after a side-effecting word is consumed.
    cyc(1, g, 1, 0, 1);
    cyc(0, '0, 1, 0, 1);
    chk("g_gp_we1", 64'(gp_we), 64'd1); chk("g_pc3", 64'(pc_mux_select), 64'd3);
    cyc(0, '0, 1, 0, 1);
    chk("g_ov0", 64'(out_valid), 64'd0);
    chk("g_gp_we0", 64'(gp_we), 64'd0);
    chk("g_wren0", 64'(mem_wren), 64'd0);
    chk("g_rren0", 64'(mem_rren), 64'd0);
    chk("g_pc0", 64'(pc_mux_select), 64'd0);
    chk("g_rd_pass", 64'(rd), 64'h13);
    chk("g_af_pass", 64'(af), 64'h6);

    // Saturation: 20 stalled cycles on a 4-bit counter starting at 5.
    cyc(1, W10, 0, 0, 1);
    for (int k = 0; k < 20; k++) cyc(0, '0, 0, 0, 1);
    chk("sat_f", 64'(stall_cnt), 64'hF);
    cyc(0, '0, 0, 0, 1); cyc(0, '0, 0, 0, 1);
    chk("sat_hold", 64'(stall_cnt), 64'hF);

    // Reset mid-stream discards the held word and clears the counter.
    @(posedge clk); #1;
    rst = 1'b1; sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mrst_ov", 64'(out_valid), 64'd0);
    chk("mrst_stall", 64'(stall_cnt), 64'd0);
    chk("mrst_fields", 64'(got_word()), 64'd0);
    repeat (2) @(negedge clk);
    chk("final_q_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
